// File: rtl/ex_mem_stage.sv
// EX stage of the RV64 pipeline: ALU control, ALU, branch resolution and the EX/MEM register.
// Valid/ready on both sides; flush kills both the held entry and the bundle offered this cycle.
module ex_mem_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_funct,
  input  logic [RD_W-1:0] id_rd,
  input  logic            id_MemtoReg,
  input  logic            id_RegWrite,
  input  logic            id_Branch,
  input  logic            id_MemWrite,
  input  logic            id_MemRead,
  input  logic            id_ALUsrc,
  input  logic [1:0]      id_ALU_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_branch_target,
  output logic            ex_branch_taken,
  output logic [RD_W-1:0] ex_rd,
  output logic            ex_MemtoReg,
  output logic            ex_RegWrite,
  output logic            ex_MemWrite,
  output logic            ex_MemRead
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLL, A_SRL, A_SRA, A_SLT
  } alu_e;

  logic            vld_q, vld_d;
  logic [XLEN-1:0] alu_q, alu_d, sd_q, sd_d, tgt_q, tgt_d;
  logic            tk_q, tk_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            m2r_q, m2r_d, rw_q, rw_d, mw_q, mw_d, mr_q, mr_d;

  alu_e            sel;
  logic [3:0]      fn;
  logic [XLEN-1:0] opb, res;
  logic [SHW-1:0]  shamt;
  logic            cond, capture;

  assign in_ready = !vld_q | out_ready;
  assign capture  = in_valid & in_ready & !flush;

  // I-type reuses the R-type map; bit3 only distinguishes SRAI from SRLI
  always_comb begin
    sel = A_ADD;
    fn  = id_funct;
    if (id_ALU_op == 2'b11 && id_funct != 4'b1101) fn[3] = 1'b0;
    case (id_ALU_op)
      2'b00: sel = A_ADD;
      2'b01: sel = A_SUB;
      default: begin
        case (fn)
          4'b0000: sel = A_ADD;
          4'b1000: sel = A_SUB;
          4'b0111: sel = A_AND;
          4'b0110: sel = A_OR;
          4'b0100: sel = A_XOR;
          4'b0001: sel = A_SLL;
          4'b0101: sel = A_SRL;
          4'b1101: sel = A_SRA;
          4'b0010: sel = A_SLT;
          default: sel = A_ADD;
        endcase
      end
    endcase
  end

  assign opb   = id_ALUsrc ? id_imm : id_rs2_data;
  assign shamt = opb[SHW-1:0];

  always_comb begin
    res = id_rs1_data + opb;
    case (sel)
      A_SUB:   res = id_rs1_data - opb;
      A_AND:   res = id_rs1_data & opb;
      A_OR:    res = id_rs1_data | opb;
      A_XOR:   res = id_rs1_data ^ opb;
      A_SLL:   res = id_rs1_data << shamt;
      A_SRL:   res = id_rs1_data >> shamt;
      A_SRA:   res = $unsigned($signed(id_rs1_data) >>> shamt);
      A_SLT:   res = {{(XLEN-1){1'b0}}, $signed(id_rs1_data) < $signed(opb)};
      default: res = id_rs1_data + opb;
    endcase
  end

  always_comb begin
    case (id_funct[2:0])
      3'b000:  cond = (id_rs1_data == id_rs2_data);
      3'b001:  cond = (id_rs1_data != id_rs2_data);
      3'b100:  cond = ($signed(id_rs1_data) <  $signed(id_rs2_data));
      3'b101:  cond = ($signed(id_rs1_data) >= $signed(id_rs2_data));
      default: cond = 1'b0;
    endcase
  end

  // Any cycle that leaves the register empty also clears the side-effecting controls
  always_comb begin
    vld_d = vld_q; alu_d = alu_q; sd_d = sd_q; tgt_d = tgt_q; tk_d = tk_q;
    rd_d = rd_q; m2r_d = m2r_q; rw_d = rw_q; mw_d = mw_q; mr_d = mr_q;
    if (flush || (!capture && out_ready)) begin
      vld_d = 1'b0;
      rw_d  = 1'b0;
      mw_d  = 1'b0;
      mr_d  = 1'b0;
      tk_d  = 1'b0;
    end else if (capture) begin
      vld_d = 1'b1;
      alu_d = res;
      sd_d  = id_rs2_data;
      tgt_d = id_pc + id_imm;
      tk_d  = id_Branch & cond;
      rd_d  = id_rd;
      m2r_d = id_MemtoReg;
      rw_d  = id_RegWrite;
      mw_d  = id_MemWrite;
      mr_d  = id_MemRead;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0; alu_q <= '0; sd_q <= '0; tgt_q <= '0; tk_q <= 1'b0;
      rd_q  <= '0;   m2r_q <= 1'b0; rw_q <= 1'b0; mw_q <= 1'b0; mr_q <= 1'b0;
    end else begin
      vld_q <= vld_d; alu_q <= alu_d; sd_q <= sd_d; tgt_q <= tgt_d; tk_q <= tk_d;
      rd_q  <= rd_d;  m2r_q <= m2r_d; rw_q <= rw_d; mw_q <= mw_d; mr_q <= mr_d;
    end
  end

  assign out_valid        = vld_q;
  assign ex_alu_result    = alu_q;
  assign ex_store_data    = sd_q;
  assign ex_branch_target = tgt_q;
  assign ex_branch_taken  = tk_q;
  assign ex_rd            = rd_q;
  assign ex_MemtoReg      = m2r_q;
  assign ex_RegWrite      = rw_q;
  assign ex_MemWrite      = mw_q;
  assign ex_MemRead       = mr_q;
endmodule
